wb_byte_master: RTL and testbench

- Wishbone initiator that turns a byte-stream command link into single Wishbone transactions.
- Typical source is an SPI byte deserializer; targets are the register slaves on the internal bus (pin config, stepper units).
- Decodes a header byte, collects write data, runs one Wishbone cycle, and returns read data as a byte stream.
- Single-transaction, no pipelining; one command in flight at a time.

---
 rtl/wb_byte_master.sv | 141 ++++++++++++++
 tb/tb_wb_byte_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_byte_master.sv
// Wishbone initiator driven by a byte-stream command link: header, optional
// 4-byte write data (MSB first), one bus cycle, 4-byte read response.
module wb_byte_master #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        timeout_err
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WDATA, BUS, TX} state_t;

    state_t      state, state_next;
    logic [1:0]  byte_cnt;
    logic [7:0]  to_cnt;
    logic [31:0] rdata;
    logic        abort_seen;
    logic        rx_fire, tx_fire, bus_done;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = rdata[31:24];
        rx_fire    = 1'b0;
        tx_fire    = 1'b0;
        // ack only counts once cyc is up; the timeout fires on the same edge otherwise
        bus_done   = wb_cyc_o && (wb_ack_i || to_cnt == TO_LAST);
        case (state)
            IDLE: begin
                rx_ready = !abort && !rst;
                rx_fire  = rx_ready && rx_valid;
                if (rx_fire) state_next = rx_data[7] ? WDATA : BUS;
            end
            WDATA: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    rx_ready = !rst;
                    rx_fire  = rx_ready && rx_valid;
                    if (rx_fire && byte_cnt == 2'd3) state_next = BUS;
                end
            end
            BUS: begin
                if (bus_done) state_next = (wb_we_o || abort_seen || abort) ? IDLE : TX;
            end
            TX: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    tx_valid = 1'b1;
                    tx_fire  = tx_ready;
                    if (tx_fire && byte_cnt == 2'd3) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            rdata       <= '0;
            byte_cnt    <= '0;
            to_cnt      <= '0;
            abort_seen  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        wb_we_o    <= rx_data[7];
                        wb_adr_o   <= rx_data[3:0];
                        byte_cnt   <= '0;
                        to_cnt     <= '0;
                        abort_seen <= 1'b0;
                    end
                end
                WDATA: begin
                    if (rx_fire) begin
                        wb_dat_o <= {wb_dat_o[23:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                BUS: begin
                    abort_seen <= abort_seen | abort;
                    byte_cnt   <= '0;
                    // cyc low inside BUS only happens on the first cycle, since completion leaves BUS
                    if (!wb_cyc_o) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        rdata    <= wb_dat_i;
                    end else if (to_cnt == TO_LAST) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rdata       <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                TX: begin
                    if (tx_fire) begin
                        rdata    <= {rdata[23:0], 8'h00};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_byte_master.sv
// Scoreboard bench for wb_byte_master: expected bus transactions and tx bytes
// are queued as commands are sent and popped as the DUT produces them.
module tb_wb_byte_master;

    logic        clk = 1'b0, rst = 1'b1, abort = 1'b0, rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = 32'h0;
    logic        wb_ack_i = 1'b0;
    logic        timeout_err;

    int errors = 0, checks = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  adr;
        logic [31:0] dat;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    bus_t        eb;
    logic [7:0]  et;

    int cyc_run = 0, last_len = 0, bus_done_cnt = 0, tx_seen = 0, ack_delay = 1;
    bit ack_tie = 1'b0, tx_toggle = 1'b0;
    logic [31:0] rd_word = 32'h0;

    wb_byte_master #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .abort(abort),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Responder, tx consumer and scoreboard, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (wb_cyc_o) begin
            cyc_run++;
        end else if (cyc_run != 0) begin
            last_len = cyc_run;
            bus_done_cnt++;
            cyc_run = 0;
        end
        wb_ack_i = ack_tie || (ack_delay != 0 && wb_cyc_o && cyc_run >= ack_delay);
        wb_dat_i = (wb_ack_i && wb_cyc_o) ? rd_word : 32'hBAD0BAD0;
        tx_ready = tx_toggle ? ~tx_ready : 1'b1;
        if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
            checks++;
            if (exp_bus.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected got we=%0b adr=%0h", wb_we_o, wb_adr_o);
            end else begin
                eb = exp_bus.pop_front();
                if ({wb_we_o, wb_adr_o} !== {eb.we, eb.adr} || (eb.we && wb_dat_o !== eb.dat)) begin
                    errors++;
                    $display("FAIL bus_txn got we=%0b adr=%0h dat=%08h exp we=%0b adr=%0h dat=%08h",
                             wb_we_o, wb_adr_o, wb_dat_o, eb.we, eb.adr, eb.dat);
                end
            end
        end
        if (tx_valid && tx_ready) begin
            tx_seen++;
            checks++;
            if (exp_tx.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got %02h", tx_data);
            end else begin
                et = exp_tx.pop_front();
                if (tx_data !== et) begin
                    errors++;
                    $display("FAIL tx_byte got %02h exp %02h", tx_data, et);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        logic acc;
        rx_valid = 1'b1;
        rx_data  = b;
        do begin
            look();
            acc = rx_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        rx_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte %02h never accepted", b);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        look();
        while (!(rx_ready && exp_tx.size() == 0 && !wb_cyc_o) && n < 300) begin
            tick();
            look();
            n++;
        end
        tick();
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_done timeout rx_ready=%0b tx_left=%0d", rx_ready, exp_tx.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        look();
        checks++;
        if ({rx_ready, tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, timeout_err} !== 50'h0) begin
            errors++;
            $display("FAIL reset_outputs got %013h exp 0", {rx_ready, tx_valid, tx_data, wb_cyc_o, wb_stb_o,
                     wb_we_o, wb_adr_o, wb_dat_o, timeout_err});
        end
        tick();
        rst = 1'b0;
        look();
        checks++;
        if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", rx_ready); end
        tick();
    endtask

    task automatic test_write();
        int base = bus_done_cnt;
        ack_tie = 1'b1; ack_delay = 1; tx_toggle = 1'b0;
        exp_bus.push_back('{1'b1, 4'h0, 32'h12345678});
        send_byte(8'h80); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        look();
        checks++;
        if ({rx_ready, wb_cyc_o} !== 2'b00) begin errors++; $display("FAIL write_entry got rdy,cyc=%b exp 00", {rx_ready, wb_cyc_o}); end
        tick(); look();
        checks++;
        if ({rx_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o} !== {1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h12345678}) begin
            errors++;
            $display("FAIL write_cycle got rdy=%b cyc=%b stb=%b we=%b adr=%h dat=%08h", rx_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o);
        end
        tick(); look();
        checks++;
        if ({rx_ready, wb_cyc_o} !== 2'b10) begin errors++; $display("FAIL write_idle got rdy,cyc=%b exp 10", {rx_ready, wb_cyc_o}); end
        tick();
        checks++;
        if (bus_done_cnt != base + 1 || last_len != 1 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL write_count got cycles=%0d len=%0d left=%0d exp 1 1 0", bus_done_cnt - base, last_len, exp_bus.size());
        end
        ack_tie = 1'b0;
    endtask

    task automatic test_read();
        int base = bus_done_cnt, tbase = tx_seen;
        rd_word = 32'hDEADBEEF; ack_delay = 1; tx_toggle = 1'b1;
        exp_bus.push_back('{1'b0, 4'h3, 32'h0});
        exp_tx.push_back(8'hDE); exp_tx.push_back(8'hAD); exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
        send_byte(8'h03);
        look();
        checks++;
        if ({tx_valid, wb_cyc_o} !== 2'b00) begin errors++; $display("FAIL read_entry got txv,cyc=%b exp 00", {tx_valid, wb_cyc_o}); end
        tick(); look();
        checks++;
        if ({tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o} !== {1'b0, 1'b1, 1'b1, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL read_cycle got txv=%b cyc=%b stb=%b we=%b adr=%h", tx_valid, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o);
        end
        tick(); look();
        checks++;
        if ({wb_cyc_o, tx_valid, tx_data} !== {1'b0, 1'b1, 8'hDE}) begin
            errors++;
            $display("FAIL read_tx_first got cyc=%b txv=%b data=%02h exp 0 1 DE", wb_cyc_o, tx_valid, tx_data);
        end
        tick();
        wait_done();
        checks++;
        if (tx_seen - tbase != 4 || bus_done_cnt - base != 1 || last_len != 1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_done got bytes=%0d cycles=%0d len=%0d txv=%b exp 4 1 1 0", tx_seen - tbase, bus_done_cnt - base, last_len, tx_valid);
        end
        tx_toggle = 1'b0;
    endtask

    task automatic test_delayed_ack();
        int base = bus_done_cnt;
        rd_word = 32'hCAFEF00D; ack_delay = 5;
        exp_bus.push_back('{1'b0, 4'h5, 32'h0});
        exp_tx.push_back(8'hCA); exp_tx.push_back(8'hFE); exp_tx.push_back(8'hF0); exp_tx.push_back(8'h0D);
        send_byte(8'h05);
        wait_done();
        checks++;
        if (last_len != 5 || bus_done_cnt - base != 1 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL delayed_ack got len=%0d cycles=%0d terr=%b exp 5 1 0", last_len, bus_done_cnt - base, timeout_err);
        end
    endtask

    task automatic test_timeout();
        int base = bus_done_cnt, tbase = tx_seen;
        ack_delay = 0;
        repeat (4) exp_tx.push_back(8'h00);
        send_byte(8'h01);
        wait_done();
        checks++;
        if (last_len != 15 || timeout_err !== 1'b1 || tx_seen - tbase != 4) begin
            errors++;
            $display("FAIL timeout_read got len=%0d terr=%b bytes=%0d exp 15 1 4", last_len, timeout_err, tx_seen - tbase);
        end
        ack_delay = 1;
        base = bus_done_cnt;
        exp_bus.push_back('{1'b1, 4'hA, 32'hA1B2C3D4});
        send_byte(8'h8A); send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        wait_done();
        checks++;
        if (bus_done_cnt - base != 1 || exp_bus.size() != 0 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_write got cycles=%0d left=%0d terr=%b exp 1 0 1", bus_done_cnt - base, exp_bus.size(), timeout_err);
        end
    endtask

    task automatic test_abort();
        int base = bus_done_cnt, tbase = tx_seen;
        ack_delay = 1; rd_word = 32'h01020304;
        send_byte(8'h81); send_byte(8'h11); send_byte(8'h22);
        abort = 1'b1;
        look();
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL abort_wdata_rdy got %b exp 0", rx_ready); end
        tick();
        rx_valid = 1'b1; rx_data = 8'h83;
        look();
        checks++;
        if (rx_ready !== 1'b0) begin errors++; $display("FAIL abort_idle_rdy got %b exp 0", rx_ready); end
        tick();
        abort = 1'b0; rx_valid = 1'b0;
        exp_bus.push_back('{1'b0, 4'h4, 32'h0});
        exp_tx.push_back(8'h01); exp_tx.push_back(8'h02); exp_tx.push_back(8'h03); exp_tx.push_back(8'h04);
        send_byte(8'h04);
        wait_done();
        checks++;
        if (bus_done_cnt - base != 1 || tx_seen - tbase != 4 || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL abort_wdata got cycles=%0d bytes=%0d left=%0d exp 1 4 0", bus_done_cnt - base, tx_seen - tbase, exp_bus.size());
        end
        base = bus_done_cnt; tbase = tx_seen; ack_delay = 3;
        exp_bus.push_back('{1'b0, 4'h6, 32'h0});
        send_byte(8'h06);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done();
        repeat (4) tick();
        checks++;
        if (bus_done_cnt - base != 1 || last_len != 3 || tx_seen != tbase || exp_bus.size() != 0) begin
            errors++;
            $display("FAIL abort_bus got cycles=%0d len=%0d bytes=%0d left=%0d exp 1 3 0 0", bus_done_cnt - base, last_len, tx_seen - tbase, exp_bus.size());
        end
    endtask

    task automatic test_reset_bus();
        ack_delay = 0;
        send_byte(8'h02);
        repeat (3) tick();
        look();
        checks++;
        if (wb_cyc_o !== 1'b1) begin errors++; $display("FAIL rstbus_pre got cyc=%b exp 1", wb_cyc_o); end
        rst = 1'b1;
        tick(); look();
        checks++;
        if ({rx_ready, tx_valid, tx_data, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, timeout_err} !== 50'h0) begin
            errors++;
            $display("FAIL rstbus_outputs got cyc=%b stb=%b terr=%b rdy=%b adr=%h", wb_cyc_o, wb_stb_o, timeout_err, rx_ready, wb_adr_o);
        end
        tick();
        rst = 1'b0;
        ack_delay = 1;
        look();
        checks++;
        if ({rx_ready, wb_cyc_o} !== 2'b10) begin errors++; $display("FAIL rstbus_after got rdy,cyc=%b exp 10", {rx_ready, wb_cyc_o}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_delayed_ack();
        test_timeout();
        test_abort();
        test_reset_bus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
